// File: rtl/clock_period_meter.sv
// Measures the period of an asynchronous square wave in inclk cycles and reports the
// divider-equivalent half-period. Optional averaging over 2^AVG_LOG2 periods: PERIOD_AVG_EN.
module clock_period_meter #(
   parameter int unsigned N        = 32,
   parameter int unsigned TIMEOUT  = 2**24,
   parameter int unsigned AVG_LOG2 = 2
) (
   input  logic         inclk,
   input  logic         rst_n,
   input  logic         meas_clk,
   input  logic         start,
   input  logic         continuous,
   output logic [N-1:0] period_count,
   output logic [N-1:0] div_count,
   output logic         valid,
   output logic         busy,
   output logic         timeout
);

   typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

   localparam logic [N-1:0] TIMEOUT_CNT = N'(TIMEOUT);

   if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << N) || AVG_LOG2 > 16)
   begin : g_param_check
      $error("clock_period_meter: TIMEOUT must be in [1, 2^N) and AVG_LOG2 <= 16");
   end

   state_t       state;
   logic [N-1:0] cnt;
   logic         meas_q1, meas_q2, meas_q3;
   logic         rise;

   // Detect latency is the same for every edge, so it drops out of the period.
   assign rise = meas_q2 & ~meas_q3;

`ifdef PERIOD_AVG_EN
   logic [AVG_LOG2-1:0]   edge_cnt;
   logic [N+AVG_LOG2-1:0] acc;
   logic [N+AVG_LOG2:0]   sum;
   logic                  last_edge;

   always_comb begin
      sum       = {1'b0, acc} + {{(AVG_LOG2+1){1'b0}}, cnt};
      last_edge = &edge_cnt;
   end
`endif

   // NOTE: every register here is sequential state, so all updates use <= to avoid
   // ordering races between the synchroniser stages and the FSM.
   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         meas_q1      <= 1'b0;
         meas_q2      <= 1'b0;
         meas_q3      <= 1'b0;
         period_count <= '0;
         div_count    <= '0;
         valid        <= 1'b0;
         busy         <= 1'b0;
         timeout      <= 1'b0;
`ifdef PERIOD_AVG_EN
         edge_cnt     <= '0;
         acc          <= '0;
`endif
      end else begin
         meas_q1 <= meas_clk;
         meas_q2 <= meas_q1;
         meas_q3 <= meas_q2;
         valid   <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= ARM;
                  busy    <= 1'b1;
                  timeout <= 1'b0;
                  cnt     <= N'(1);
               end
            end

            ARM: begin
               if (rise) begin
                  state <= COUNT;
                  cnt   <= N'(1);
`ifdef PERIOD_AVG_EN
                  edge_cnt <= '0;
                  acc      <= '0;
`endif
               end else if (cnt == TIMEOUT_CNT) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  cnt <= cnt + N'(1);
               end
            end

            COUNT: begin
               if (rise) begin
                  cnt <= N'(1);
`ifdef PERIOD_AVG_EN
                  if (last_edge) begin
                     period_count <= sum[AVG_LOG2 +: N];
                     div_count    <= sum[AVG_LOG2+1 +: N];
                     valid        <= 1'b1;
                     state        <= DONE;
                  end else begin
                     acc      <= sum[N+AVG_LOG2-1:0];
                     edge_cnt <= edge_cnt + 1'b1;
                  end
`else
                  period_count <= cnt;
                  div_count    <= cnt >> 1;
                  valid        <= 1'b1;
                  state        <= DONE;
`endif
               end else if (cnt == TIMEOUT_CNT) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  cnt <= cnt + N'(1);
               end
            end

            DONE: begin
               if (continuous) begin
                  // The closing edge opens the next period; this cycle is already its first.
                  state <= COUNT;
                  cnt   <= cnt + N'(1);
`ifdef PERIOD_AVG_EN
                  edge_cnt <= '0;
                  acc      <= '0;
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter; meas_clk is generated on inclk
// falling edges so rise-to-rise distances are exact inclk cycle counts.
module tb_clock_period_meter;

   localparam int N = 32;
`ifdef PERIOD_AVG_EN
   localparam int AVG_PERIODS = 4;
`else
   localparam int AVG_PERIODS = 1;
`endif

   logic         inclk;
   logic         rst_n;
   logic         meas_clk;
   logic         start;
   logic         continuous;
   logic [N-1:0] period_count;
   logic [N-1:0] div_count;
   logic         valid;
   logic         busy;
   logic         timeout;

   int checks = 0;
   int errors = 0;

   logic gen_en = 1'b0;
   logic alt_en = 1'b0;
   int   hi_len = 5;
   int   lo_len = 5;

   clock_period_meter #(.N(N), .TIMEOUT(1000), .AVG_LOG2(2)) dut (
      .inclk       (inclk),
      .rst_n       (rst_n),
      .meas_clk    (meas_clk),
      .start       (start),
      .continuous  (continuous),
      .period_count(period_count),
      .div_count   (div_count),
      .valid       (valid),
      .busy        (busy),
      .timeout     (timeout)
   );

   initial begin
      inclk = 1'b0;
      forever #5 inclk = ~inclk;
   end

   // meas_clk generator; with alt_en, periods alternate 11 and 9 cycles.
   initial begin
      int  ph;
      logic sel;
      ph = 0;
      sel = 1'b0;
      meas_clk = 1'b0;
      forever begin
         @(negedge inclk);
         if (!gen_en) begin
            meas_clk = 1'b0;
            ph = 0;
         end else begin
            ph++;
            if (meas_clk) begin
               if (ph >= hi_len) begin
                  meas_clk = 1'b0;
                  ph = 0;
               end
            end else if (ph >= lo_len) begin
               meas_clk = 1'b1;
               ph = 0;
               if (alt_en) begin
                  sel = ~sel;
                  hi_len = sel ? 5 : 4;
                  lo_len = sel ? 6 : 5;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge inclk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output logic got, output int waited);
      got = 1'b0;
      waited = 0;
      while (!got && waited < limit) begin
         tick();
         waited++;
         if (valid === 1'b1) got = 1'b1;
      end
   endtask

   task automatic do_reset();
      start = 1'b0;
      continuous = 1'b0;
      gen_en = 1'b0;
      alt_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (period_count !== '0) begin errors++; $display("FAIL reset_period got %0d want 0", period_count); end
      checks++; if (div_count !== '0) begin errors++; $display("FAIL reset_div got %0d want 0", div_count); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
   endtask

   task automatic test_single(input int hi, input int lo, input int exp_p, input int exp_d);
      logic got;
      int   waited;
      int   extra;
      do_reset();
      hi_len = hi;
      lo_len = lo;
      gen_en = 1'b1;
      repeat (4) tick();
      pulse_start();
      wait_valid(60 * AVG_PERIODS, got, waited);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", got); end
      checks++; if (period_count !== N'(exp_p)) begin errors++; $display("FAIL single_period got %0d want %0d", period_count, exp_p); end
      checks++; if (div_count !== N'(exp_d)) begin errors++; $display("FAIL single_div got %0d want %0d", div_count, exp_d); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done got %b want 1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_width got %b want 0", valid); end
      extra = 0;
      repeat (40 * AVG_PERIODS) begin
         tick();
         if (valid === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL single_extra_valid got %0d want 0", extra); end
   endtask

   task automatic test_continuous();
      logic got;
      int   waited;
      int   extra;
      do_reset();
      hi_len = 18;
      lo_len = 19;
      gen_en = 1'b1;
      continuous = 1'b1;
      repeat (4) tick();
      pulse_start();
      wait_valid(100 * AVG_PERIODS, got, waited);
      checks++; if (got !== 1'b1 || period_count !== N'(37)) begin errors++; $display("FAIL cont_first got %0d want 37", period_count); end
      for (int i = 0; i < 3; i++) begin
         wait_valid(60 * AVG_PERIODS, got, waited);
         checks++; if (got !== 1'b1 || waited != 37 * AVG_PERIODS) begin errors++; $display("FAIL cont_spacing got %0d want %0d", waited, 37 * AVG_PERIODS); end
         checks++; if (period_count !== N'(37) || div_count !== N'(18)) begin errors++; $display("FAIL cont_value got %0d/%0d want 37/18", period_count, div_count); end
      end
      repeat (10) tick();
      continuous = 1'b0;
      wait_valid(60 * AVG_PERIODS, got, waited);
      checks++; if (got !== 1'b1 || period_count !== N'(37)) begin errors++; $display("FAIL cont_last got %b/%0d want 1/37", got, period_count); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end got %b want 0", busy); end
      extra = 0;
      repeat (100 * AVG_PERIODS) begin
         tick();
         if (valid === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL cont_extra_valid got %0d want 0", extra); end
   endtask

   task automatic test_timeout();
      int nvalid;
      do_reset();
      pulse_start();
      nvalid = 0;
      repeat (999) begin
         tick();
         if (valid === 1'b1) nvalid++;
      end
      checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got busy=%b to=%b want 1/0", busy, timeout); end
      tick();
      checks++; if (busy !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_fire got busy=%b to=%b want 0/1", busy, timeout); end
      checks++; if (nvalid != 0 || valid !== 1'b0) begin errors++; $display("FAIL timeout_valid got %0d want 0", nvalid); end
      repeat (5) tick();
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", timeout); end
      pulse_start();
      checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_clear got to=%b busy=%b want 0/1", timeout, busy); end
   endtask

   task automatic test_start_ignored();
      logic got;
      int   n;
      do_reset();
      hi_len = 5;
      lo_len = 5;
      gen_en = 1'b1;
      repeat (4) tick();
      pulse_start();
      got = 1'b0;
      n = 0;
      while (!got && n < 60 * AVG_PERIODS) begin
         start = (n % 3 == 0);
         tick();
         n++;
         if (valid === 1'b1) got = 1'b1;
      end
      checks++; if (got !== 1'b1 || period_count !== N'(10)) begin errors++; $display("FAIL ignore_period got %0d want 10", period_count); end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_start got busy=%b want 0", busy); end
      pulse_start();
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      checks++; if (period_count !== '0 || div_count !== '0) begin errors++; $display("FAIL rst_mid_counts got %0d/%0d want 0/0", period_count, div_count); end
      checks++; if (valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got v=%b b=%b t=%b want 0", valid, busy, timeout); end
      tick();
      rst_n = 1'b1;
      n = 0;
      repeat (40) begin
         tick();
         if (valid === 1'b1 || busy === 1'b1) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL rst_mid_idle got %0d active cycles want 0", n); end
   endtask

   task automatic test_switch();
      logic got;
      int   waited;
      int   guard;
      do_reset();
      hi_len = 5;
      lo_len = 5;
      gen_en = 1'b1;
      continuous = 1'b1;
      repeat (4) tick();
      pulse_start();
      for (int i = 0; i < 2; i++) begin
         wait_valid(40 * AVG_PERIODS, got, waited);
         checks++; if (got !== 1'b1 || period_count !== N'(10)) begin errors++; $display("FAIL switch_pre got %0d want 10", period_count); end
      end
      @(negedge meas_clk);
      hi_len = 20;
      lo_len = 20;
      wait_valid(100 * AVG_PERIODS, got, waited);
      guard = 0;
      while (got && period_count == N'(10) && guard < 3) begin
         wait_valid(100 * AVG_PERIODS, got, waited);
         guard++;
      end
`ifndef PERIOD_AVG_EN
      checks++; if (got !== 1'b1 || period_count !== N'(25)) begin errors++; $display("FAIL switch_transition got %0d want 25", period_count); end
      wait_valid(100, got, waited);
`else
      wait_valid(200 * AVG_PERIODS, got, waited);
`endif
      checks++; if (got !== 1'b1 || period_count !== N'(40) || div_count !== N'(20)) begin errors++; $display("FAIL switch_post got %0d/%0d want 40/20", period_count, div_count); end
      wait_valid(60 * AVG_PERIODS, got, waited);
      checks++; if (got !== 1'b1 || period_count !== N'(40) || waited != 40 * AVG_PERIODS) begin errors++; $display("FAIL switch_steady got %0d after %0d want 40", period_count, waited); end
      continuous = 1'b0;
   endtask

`ifdef PERIOD_AVG_EN
   task automatic test_average();
      logic got;
      int   waited;
      int   extra;
      do_reset();
      alt_en = 1'b1;
      gen_en = 1'b1;
      repeat (4) tick();
      pulse_start();
      wait_valid(120, got, waited);
      checks++; if (got !== 1'b1 || period_count !== N'(10) || div_count !== N'(5)) begin errors++; $display("FAIL avg_value got %0d/%0d want 10/5", period_count, div_count); end
      extra = 0;
      repeat (60) begin
         tick();
         if (valid === 1'b1) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL avg_single_valid got %0d extra want 0", extra); end
      alt_en = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      continuous = 1'b0;
      test_reset();
      test_single(5, 5, 10, 5);
      test_single(5, 6, 11, 5);
      test_continuous();
      test_timeout();
      test_start_ignored();
      test_switch();
`ifdef PERIOD_AVG_EN
      test_average();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
